// File: rtl/conv_relu_pool.sv
// Requantise + ReLU of raster-order convolution sums followed by 2x2 max pooling.
// Two register stages: requantise/tag, then pair/line-buffer max and output.
module conv_relu_pool #(
  parameter int unsigned NUM_TREES  = 1,
  parameter int unsigned IMG_WIDTH  = 4,
  parameter int unsigned IMG_HEIGHT = 4,
  parameter int unsigned SHIFT      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [32*NUM_TREES-1:0]  pixel_in,
  output logic [8*NUM_TREES-1:0]   pixel_out,
  output logic                     out_valid,
  output logic                     frame_done
);

  localparam int unsigned CW  = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned LBD = IMG_WIDTH / 2;
  localparam int unsigned LBW = (LBD > 1) ? $clog2(LBD) : 1;
  localparam int unsigned PW  = 8 * NUM_TREES;

  // Raster position of the incoming beat
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Requantisation: ReLU, arithmetic shift, saturate to 8 bits
  logic        [PW-1:0] w_q;
  logic signed [31:0]   w_x;
  logic signed [31:0]   w_sh;

  always_comb begin
    w_q  = '0;
    w_x  = '0;
    w_sh = '0;
    for (int i = 0; i < NUM_TREES; i++) begin
      w_x  = pixel_in[32*i +: 32];
      w_sh = w_x >>> SHIFT;
      if (w_x[31]) begin
        w_q[8*i +: 8] = 8'd0;
      end else if (|w_sh[31:8]) begin
        w_q[8*i +: 8] = 8'd255;
      end else begin
        w_q[8*i +: 8] = w_sh[7:0];
      end
    end
  end

  // Stage 1 registers
  logic          r_s1_valid;
  logic [PW-1:0] r_s1_q;
  logic [CW-1:0] r_s1_col;
  logic [RW-1:0] r_s1_row;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_q     <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_q   <= w_q;
        r_s1_col <= r_col;
        r_s1_row <= r_row;
      end
    end
  end

  // Stage 2: horizontal pair max, vertical max against the line buffer
  logic [PW-1:0]  r_pair;
  logic [PW-1:0]  r_linebuf [LBD];
  logic [LBW-1:0] w_lb_idx;
  logic [PW-1:0]  w_lb_rd;
  logic [PW-1:0]  w_m;
  logic [PW-1:0]  w_pool;
  logic           w_odd_col;
  logic           w_odd_row;
  logic           w_emit;
  logic           w_last_px;

  assign w_odd_col = r_s1_col[0];
  assign w_odd_row = r_s1_row[0];
  assign w_lb_idx  = LBW'(r_s1_col >> 1);
  assign w_lb_rd   = r_linebuf[w_lb_idx];
  assign w_emit    = r_s1_valid && w_odd_col && w_odd_row;
  assign w_last_px = (r_s1_col == CW'(IMG_WIDTH - 1)) && (r_s1_row == RW'(IMG_HEIGHT - 1));

  always_comb begin
    w_m    = '0;
    w_pool = '0;
    for (int i = 0; i < NUM_TREES; i++) begin
      w_m[8*i +: 8] = (r_pair[8*i +: 8] > r_s1_q[8*i +: 8]) ?
                      r_pair[8*i +: 8] : r_s1_q[8*i +: 8];
      w_pool[8*i +: 8] = (w_m[8*i +: 8] > w_lb_rd[8*i +: 8]) ?
                         w_m[8*i +: 8] : w_lb_rd[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pair <= '0;
    end else if (r_s1_valid && !w_odd_col) begin
      r_pair <= r_s1_q;
    end
  end

  // Every entry is written on the even row before the odd row reads it
  always_ff @(posedge clock) begin
    if (r_s1_valid && w_odd_col && !w_odd_row) begin
      r_linebuf[w_lb_idx] <= w_m;
    end
  end

  logic [PW-1:0] r_pixel_out;
  logic          r_out_valid;
  logic          r_frame_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pixel_out  <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= w_emit && w_last_px;
      if (w_emit) begin
        r_pixel_out <= w_pool;
      end
    end
  end

  assign pixel_out  = r_pixel_out;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_relu_pool.sv
// Self-checking bench for conv_relu_pool: table of 2x2 windows with hand-derived
// pooled results, driven as raster frames and checked through a scoreboard.
module tb_conv_relu_pool;

  localparam int NT = 2;
  localparam int W  = 4;
  localparam int H  = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic [32*NT-1:0] pixel_in = '0;
  logic [8*NT-1:0]  pixel_out;
  logic           out_valid;
  logic           frame_done;

  conv_relu_pool #(
    .NUM_TREES (NT),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .SHIFT     (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .pixel_in  (pixel_in),
    .pixel_out (pixel_out),
    .out_valid (out_valid),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // One 2x2 window: v[0]=top-left, v[1]=top-right, v[2]=bottom-left, v[3]=bottom-right.
  // Channel 1 is fed 2 x channel 0; e0/e1 are the expected pooled results.
  typedef struct packed {
    logic [3:0][31:0] v;
    logic [7:0]       e0;
    logic [7:0]       e1;
  } win_t;

  typedef struct {
    logic [15:0] pix;
    logic        fd;
    int          cyc;
  } exp_t;

  win_t tbl [8];
  exp_t sbq [$];
  int   errors = 0;
  int   checks = 0;
  logic [15:0] last_pix = '0;

  function automatic win_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input logic [7:0] e0, input logic [7:0] e1);
    win_t w;
    w.v[0] = a;
    w.v[1] = b;
    w.v[2] = c;
    w.v[3] = d;
    w.e0   = e0;
    w.e1   = e1;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic beat(input logic [31:0] d0, input bit push, input logic [15:0] ep,
                      input logic efd);
    logic [31:0] d1;
    exp_t e;
    d1 = d0 << 1;
    @(negedge clock);
    in_valid = 1'b1;
    pixel_in = {d1, d0};
    if (push) begin
      e.pix = ep;
      e.fd  = efd;
      e.cyc = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  // Drives frame made of windows base..base+3 in raster order; stops after nbeats beats.
  task automatic send_frame(input int base, input int gap, input int nbeats, input bit push);
    int   n;
    int   idx;
    win_t w;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < nbeats) begin
          idx = base + (r / 2) * (W / 2) + (c / 2);
          w   = tbl[idx];
          beat(w.v[(r % 2) * 2 + (c % 2)], push && (r % 2 == 1) && (c % 2 == 1),
               {w.e1, w.e0}, (r == H - 1) && (c == W - 1));
          n++;
          if (gap > 0) idle(gap);
        end
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each out_valid, checks hold/idle otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        last_pix = '0;
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("pixel_out", 64'(pixel_out), 64'(e.pix));
          check("frame_done", 64'(frame_done), 64'(e.fd));
          check("latency_cycle", 64'(cyc), 64'(e.cyc));
        end
        last_pix = pixel_out;
      end else begin
        check("frame_done_idle", 64'(frame_done), 64'd0);
        check("pixel_hold", 64'(pixel_out), 64'(last_pix));
      end
    end
  end

  initial begin
    int wait_cnt;
    tbl[0] = mk(32'd16, 32'd32, 32'd80, -32'sd5, 8'd5, 8'd10);
    tbl[1] = mk(32'd48, 32'd64, 32'd0, 32'd160, 8'd10, 8'd20);
    tbl[2] = mk(32'h0000_1000, 32'hFFFF_FFF0, 32'h8000_0000, 32'd0, 8'd255, 8'd255);
    tbl[3] = mk(32'hFFFF_FFFF, -32'sd100, -32'sd16, 32'h8000_0001, 8'd0, 8'd0);
    tbl[4] = mk(32'h900, 32'h10, 32'h7FF, 32'h20, 8'd144, 8'd255);
    tbl[5] = mk(32'h0F, 32'h1F, 32'h2F, 32'h3F, 8'd3, 8'd7);
    tbl[6] = mk(32'h7FFF_FFFF, 32'd5, 32'd5, 32'd5, 8'd255, 8'd0);
    tbl[7] = mk(32'h800, 32'h7F0, 32'h100, 32'h050, 8'd128, 8'd255);

    // Reset with in_valid high beforehand
    in_valid = 1'b1;
    pixel_in = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_pixel_out", 64'(pixel_out), 64'd0);
    end
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("post_rst_quiet", 64'(out_valid), 64'd0);
    end

    // Back-to-back frames A, B, A: wrap with no idle, frame repeatability
    send_frame(0, 0, 16, 1'b1);
    send_frame(4, 0, 16, 1'b1);
    send_frame(0, 0, 16, 1'b1);
    idle(6);

    // Gapped input, then a continuous frame leaving a nonzero pixel_out
    send_frame(0, 3, 16, 1'b1);
    send_frame(4, 0, 16, 1'b1);
    idle(6);

    // Mid-frame reset after 6 beats; the row-1/col-1 result must be discarded
    send_frame(0, 0, 6, 1'b0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    pixel_in = {$urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_pixel_out", 64'(pixel_out), 64'd0);
      check("midrst_frame_done", 64'(frame_done), 64'd0);
    end
    sbq.delete();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("midrst_release_quiet", 64'(out_valid), 64'd0);
    end
    send_frame(4, 0, 16, 1'b1);

    // Bounded drain of outstanding expectations
    wait_cnt = 0;
    while (sbq.size() > 0 && wait_cnt < 20) begin
      @(negedge clock);
      wait_cnt++;
    end
    idle(4);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_relu_pool.md
CONV_RELU_POOL -- requirements
Module: conv_relu_pool

Interface
REQ-001 The block SHALL have parameter NUM_TREES, default 1: number of parallel 32-bit convolution channels consumed per beat.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 4: convolution output pixels per row; even, >=2.
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 4: convolution output rows per frame; even, >=2.
REQ-004 The block SHALL have parameter SHIFT, default 4: requantisation right-shift amount, 0..31.
REQ-005 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid  input  1  pixel_in carries one valid raster-order beat this cycle.
REQ-008 The block SHALL have port pixel_in  input  32*NUM_TREES  signed two's-complement conv sums; channel i at bits [32*i+31:32*i].
REQ-009 The block SHALL have port pixel_out  output  8*NUM_TREES  unsigned pooled pixels; channel i at bits [8*i+7:8*i].
REQ-010 The block SHALL have port out_valid  output  1  pixel_out is valid this cycle; single-cycle pulse per pooled pixel.
REQ-011 The block SHALL have port frame_done  output  1  single-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-012 Stage 1 SHALL register, per channel, q = 0 if negative, else min(x >>> SHIFT, 255), 8-bit; it SHALL also register valid, column and row tags.
REQ-013 The column counter (0..IMG_WIDTH-1) SHALL advance only on in_valid; it SHALL wrap to 0 after IMG_WIDTH-1 and advance the row counter.
REQ-014 The row counter (0..IMG_HEIGHT-1) SHALL wrap to 0 after IMG_HEIGHT-1, starting a new frame with no idle cycle required.
REQ-015 Even columns SHALL hold q in a per-channel pair register; odd columns SHALL form pair max m = max(held, q).
REQ-016 On even rows, m SHALL be written to line buffer entry col/2 (IMG_WIDTH/2 entries x 8*NUM_TREES bits).
REQ-017 On odd rows at odd columns, stage 2 SHALL register pixel_out = max(m, linebuf[col/2]) and assert out_valid.
REQ-018 Latency SHALL be 2 cycles: an accepted beat at odd row/odd column in cycle N yields out_valid in cycle N+2.
REQ-019 out_valid SHALL NOT assert for any other beat; pixel_out SHALL hold its last value while out_valid is low.
REQ-020 frame_done SHALL assert with out_valid for the beat at row IMG_HEIGHT-1, column IMG_WIDTH-1, and at no other time.
REQ-021 in_valid low SHALL freeze counters, pair registers and line buffer; gaps of any length SHALL not alter results.
REQ-022 The block SHALL have no backpressure; it SHALL accept one beat every cycle indefinitely.
REQ-023 Every channel SHALL be processed identically and independently in lockstep.
REQ-024 Comparisons SHALL be unsigned on the 8-bit requantised values.

Reset
REQ-025 While reset is low: out_valid=0, frame_done=0, pixel_out=0, counters=0, pair registers=0, stage-1 valid=0.
REQ-026 Line buffer contents SHALL NOT require reset; every entry is written before it is read in each frame.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first beat after release SHALL be row 0, column 0.
REQ-028 No out_valid SHALL appear on the first two cycles after reset release, even if in_valid was high before reset.

Verification (NUM_TREES=1, IMG_WIDTH=4, IMG_HEIGHT=4, SHIFT=4)
REQ-029 Basic pool: row0 = 16,32,48,64; row1 = 80,-5,0,160, continuous -> out_valid pulses carrying 5 then 10, each 2 cycles after its odd-column beat.
REQ-030 Saturate/ReLU: window of 32'h0000_1000, 32'hFFFF_FFF0, 32'h8000_0000, 0 -> pooled 255; all-negative window -> 0.
REQ-031 Gapped input: the REQ-029 data with in_valid low 3 cycles between every beat -> identical values 5, 10; no extra out_valid.
REQ-032 Full frame / wrap: two back-to-back frames of 16 beats -> 4 outputs each; frame_done only on the 4th output of each frame; frame 2 outputs equal frame 1.
REQ-033 Reset mid-frame: assert reset after 6 beats, release, then send a full frame -> outputs reset to 0 during reset, then exactly 4 correct pooled values with no stale output.
REQ-034 Multi-channel: NUM_TREES=2 with channel 1 = 2 x channel 0 data -> each channel's results independently correct, saturating per channel.
